// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: branch flushes, RAW stall/forward
// selection, and a one-deep multi-cycle scoreboard with a stall counter.
module hazard_scoreboard_unit #(
    parameter int REGW   = 5,
    parameter int NSRC   = 2,
    parameter int FWD_EN = 1,
    parameter int LATW   = 4,
    parameter int SCNTW  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NSRC*REGW-1:0]   src_reg,
    input  logic [NSRC-1:0]        src_vld,
    input  logic                   id_mc,
    input  logic [REGW-1:0]        ex_wreg,
    input  logic                   ex_regWEN,
    input  logic                   ex_is_load,
    input  logic [REGW-1:0]        mem_wreg,
    input  logic                   mem_regWEN,
    input  logic                   branchorjump,
    input  logic                   branchorjump_wb,
    input  logic                   mc_issue,
    input  logic [REGW-1:0]        mc_dest,
    input  logic [LATW-1:0]        mc_lat,
    output logic                   flush2,
    output logic                   flush3,
    output logic                   disable_fetch,
    output logic [2*NSRC-1:0]      fwd_sel,
    output logic                   mc_busy,
    output logic                   mc_wb,
    output logic [REGW-1:0]        mc_wb_reg,
    output logic [SCNTW-1:0]       stall_cnt
);

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_BUSY,
        MC_DONE
    } mc_state_e;

    localparam logic [LATW-1:0] LAT_ONE = LATW'(1);

    mc_state_e         state_q, state_d;
    logic [LATW-1:0]   cnt_q, cnt_d;
    logic [REGW-1:0]   pend_q, pend_d;
    logic [SCNTW-1:0]  stall_cnt_q, stall_cnt_d;

    logic              flush;
    logic              busy;
    logic              stall;
    logic [2*NSRC-1:0] fwd;
    logic              load_op;
    logic [LATW-1:0]   lat_eff;

    always_comb begin
        logic [REGW-1:0] s;
        logic            live;
        logic            ex_hit;
        logic            mem_hit;
        flush = branchorjump | branchorjump_wb;
        busy  = (state_q != MC_IDLE);
        stall = id_mc && (state_q == MC_BUSY);
        fwd   = '0;
        for (int i = 0; i < NSRC; i++) begin
            s       = src_reg[i*REGW +: REGW];
            live    = src_vld[i] && (s != '0);
            ex_hit  = live && ex_regWEN && (s == ex_wreg);
            mem_hit = live && mem_regWEN && (s == mem_wreg);
            if (FWD_EN != 0) begin
                if (ex_hit && ex_is_load) begin
                    stall = 1'b1;
                end
                if (ex_hit && !ex_is_load) begin
                    fwd[2*i +: 2] = 2'b01;
                end else if (mem_hit) begin
                    fwd[2*i +: 2] = 2'b10;
                end
            end else if (ex_hit || mem_hit) begin
                stall = 1'b1;
            end
            // pending result stays visible through DONE, its writeback cycle
            if (busy && live && (s == pend_q)) begin
                stall = 1'b1;
            end
        end
    end

    always_comb begin
        flush2        = 1'b0;
        flush3        = 1'b0;
        disable_fetch = 1'b0;
        fwd_sel       = '0;
        mc_busy       = 1'b0;
        mc_wb         = 1'b0;
        mc_wb_reg     = '0;
        if (!RST) begin
            if (flush) begin
                flush2 = 1'b1;
                flush3 = 1'b1;
            end else if (stall) begin
                flush2        = 1'b1;
                disable_fetch = 1'b1;
            end
            fwd_sel = fwd;
            mc_busy = busy;
            if (state_q == MC_DONE) begin
                mc_wb     = 1'b1;
                mc_wb_reg = pend_q;
            end
        end
    end

    always_comb begin
        load_op = mc_issue && !flush;
        lat_eff = (mc_lat == '0) ? LAT_ONE : mc_lat;
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            MC_BUSY: begin
                cnt_d = cnt_q - LAT_ONE;
                if (cnt_d == LAT_ONE) begin
                    state_d = MC_DONE;
                end
            end
            MC_IDLE, MC_DONE: begin
                state_d = MC_IDLE;
                if (load_op) begin
                    pend_d  = mc_dest;
                    cnt_d   = lat_eff;
                    // single-cycle ops reach writeback without a BUSY cycle
                    state_d = (lat_eff == LAT_ONE) ? MC_DONE : MC_BUSY;
                end
            end
            default: state_d = MC_IDLE;
        endcase
        stall_cnt_d = stall_cnt_q;
        if (disable_fetch && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + SCNTW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= MC_IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
